// File: rtl/down_counter_pkg.sv
// Shared types and constants for the loadable down-counter/timer.
package down_counter_pkg;

  // Controller states: waiting for a load, counting down, finished one-shot.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default counter / load-value width.
  localparam int DEFAULT_WIDTH = 8;

endpackage : down_counter_pkg

// File: rtl/down_counter.sv
// Loadable down-counter/timer. It loads a start value and decrements once per
// enabled cycle while running. On the 1 -> terminal step it emits a
// single-cycle expired pulse. It then either reloads the captured start value
// or parks at zero in DONE.
module down_counter
  import down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             count,
  input  logic             auto_reload,
  input  logic             stop,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             expired_o,
  output logic             busy_o
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state_reg,   state_next;
  logic [WIDTH-1:0] data_reg,    data_next;
  logic [WIDTH-1:0] reload_reg,  reload_next;
  logic             expired_reg, expired_next;

  // Next-state logic. Priority: load > stop > terminal count > decrement > hold.
  always_comb begin
    state_next   = state_reg;
    data_next    = data_reg;
    reload_next  = reload_reg;
    expired_next = 1'b0;

    if (load) begin
      // A zero load leaves nothing to count, so it stays idle without a pulse.
      data_next   = load_value;
      reload_next = load_value;
      state_next  = (load_value != ZERO) ? RUN : IDLE;
    end else if (stop) begin
      data_next  = ZERO;
      state_next = IDLE;
    end else if (state_reg == RUN && count) begin
      if (data_reg == ONE) begin
        expired_next = 1'b1;
        if (auto_reload) begin
          data_next  = reload_reg;
          state_next = RUN;
        end else begin
          data_next  = ZERO;
          state_next = DONE;
        end
      end else if (data_reg > ONE) begin
        // The guard keeps the counter from wrapping if RUN is ever seen at zero.
        data_next = data_reg - ONE;
      end
    end
  end

  // State, counter, reload value and expired pulse registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      data_reg    <= ZERO;
      reload_reg  <= ZERO;
      expired_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      data_reg    <= data_next;
      reload_reg  <= reload_next;
      expired_reg <= expired_next;
    end
  end

  assign data_o    = data_reg;
  assign zero_o    = (data_reg == ZERO);
  assign expired_o = expired_reg;
  assign busy_o    = (state_reg == RUN);

endmodule : down_counter

// File: tb/tb_down_counter.sv
// Directed testbench for down_counter. Each task drives one scenario and
// checks the outputs against hand-computed values.
module tb_down_counter;

  localparam int W = 8;

  logic         clock;
  logic         reset_n;
  logic         load;
  logic [W-1:0] load_value;
  logic         count;
  logic         auto_reload;
  logic         stop;
  logic [W-1:0] data_o;
  logic         zero_o;
  logic         expired_o;
  logic         busy_o;

  int total = 0;
  int bad   = 0;

  down_counter #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .load        (load),
    .load_value  (load_value),
    .count       (count),
    .auto_reload (auto_reload),
    .stop        (stop),
    .data_o      (data_o),
    .zero_o      (zero_o),
    .expired_o   (expired_o),
    .busy_o      (busy_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge, then settle 1 ns so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    // Outputs while reset is held from time zero.
    #2;
    total++;
    if (data_o !== 8'd0 || zero_o !== 1'b1 || busy_o !== 1'b0 || expired_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_init: data=%0d zero=%0b busy=%0b exp=%0b required data=0 zero=1 busy=0 exp=0",
               data_o, zero_o, busy_o, expired_o);
    end
    $display("reset_init: data=%0d zero=%0b busy=%0b", data_o, zero_o, busy_o);
    @(negedge clock);
    reset_n = 1'b1;
    // Bring the counter to 5 mid-RUN, then assert reset between clock edges.
    load = 1'b1; load_value = 8'd8; count = 1'b1;
    tick();
    load = 1'b0;
    tick(); tick(); tick();
    total++;
    if (data_o !== 8'd5 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre: data=%0d busy=%0b required data=5 busy=1", data_o, busy_o);
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (data_o !== 8'd0 || zero_o !== 1'b1 || busy_o !== 1'b0 || expired_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: data=%0d zero=%0b busy=%0b exp=%0b required data=0 zero=1 busy=0 exp=0",
               data_o, zero_o, busy_o, expired_o);
    end
    $display("reset_async: data=%0d zero=%0b busy=%0b exp=%0b", data_o, zero_o, busy_o, expired_o);
    count = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_one_shot();
    logic [W-1:0] exp_data [4] = '{8'd3, 8'd2, 8'd1, 8'd0};
    logic         exp_pulse[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic         exp_busy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    load = 1'b1; load_value = 8'd3; count = 1'b1; auto_reload = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      load = 1'b0;
      total++;
      if (data_o !== exp_data[i] || expired_o !== exp_pulse[i] || busy_o !== exp_busy[i]) begin
        bad++;
        $display("FAIL one_shot[%0d]: data=%0d exp=%0b busy=%0b required data=%0d exp=%0b busy=%0b",
                 i, data_o, expired_o, busy_o, exp_data[i], exp_pulse[i], exp_busy[i]);
      end
      $display("one_shot[%0d]: data=%0d exp=%0b busy=%0b", i, data_o, expired_o, busy_o);
    end
    // DONE ignores count and holds zero; the pulse is a single cycle.
    tick(); tick();
    total++;
    if (data_o !== 8'd0 || expired_o !== 1'b0 || busy_o !== 1'b0 || zero_o !== 1'b1) begin
      bad++;
      $display("FAIL one_shot_done: data=%0d exp=%0b busy=%0b zero=%0b required data=0 exp=0 busy=0 zero=1",
               data_o, expired_o, busy_o, zero_o);
    end
    $display("one_shot_done: data=%0d exp=%0b", data_o, expired_o);
    count = 1'b0;
  endtask

  task automatic test_auto_reload();
    logic [W-1:0] exp_data [12] = '{8'd3, 8'd2, 8'd1, 8'd4, 8'd3, 8'd2, 8'd1, 8'd4,
                                    8'd3, 8'd2, 8'd1, 8'd4};
    logic         exp_pulse[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                                    1'b0, 1'b0, 1'b0, 1'b1};
    load = 1'b1; load_value = 8'd4; count = 1'b0; auto_reload = 1'b1;
    tick();
    load = 1'b0; count = 1'b1;
    total++;
    if (data_o !== 8'd4 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL reload_load: data=%0d busy=%0b required data=4 busy=1", data_o, busy_o);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      total++;
      if (data_o !== exp_data[i] || expired_o !== exp_pulse[i] || busy_o !== 1'b1) begin
        bad++;
        $display("FAIL reload[%0d]: data=%0d exp=%0b busy=%0b required data=%0d exp=%0b busy=1",
                 i, data_o, expired_o, busy_o, exp_data[i], exp_pulse[i]);
      end
      $display("reload[%0d]: data=%0d exp=%0b busy=%0b", i, data_o, expired_o, busy_o);
    end
    count = 1'b0; auto_reload = 1'b0;
  endtask

  task automatic test_count_toggle();
    logic         cnt     [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] exp_data[4] = '{8'd4, 8'd4, 8'd3, 8'd3};
    load = 1'b1; load_value = 8'd5; count = 1'b0;
    tick();
    load = 1'b0;
    total++;
    if (data_o !== 8'd5) begin
      bad++;
      $display("FAIL toggle_load: data=%0d required 5", data_o);
    end
    for (int i = 0; i < 4; i++) begin
      count = cnt[i];
      tick();
      total++;
      if (data_o !== exp_data[i] || expired_o !== 1'b0) begin
        bad++;
        $display("FAIL toggle[%0d]: data=%0d exp=%0b required data=%0d exp=0",
                 i, data_o, expired_o, exp_data[i]);
      end
      $display("toggle[%0d]: count=%0b data=%0d", i, cnt[i], data_o);
    end
    count = 1'b0;
  endtask

  task automatic test_load_at_terminal();
    load = 1'b1; load_value = 8'd2; count = 1'b1; auto_reload = 1'b0;
    tick();
    load = 1'b0;
    tick();
    total++;
    if (data_o !== 8'd1) begin
      bad++;
      $display("FAIL load_term_pre: data=%0d required 1", data_o);
    end
    // Terminal step and load on the same edge: load must win.
    load = 1'b1; load_value = 8'd9;
    tick();
    load = 1'b0; count = 1'b0;
    total++;
    if (data_o !== 8'd9 || expired_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL load_term: data=%0d exp=%0b busy=%0b required data=9 exp=0 busy=1",
               data_o, expired_o, busy_o);
    end
    $display("load_term: data=%0d exp=%0b busy=%0b", data_o, expired_o, busy_o);
    tick();
    total++;
    if (expired_o !== 1'b0 || data_o !== 8'd9) begin
      bad++;
      $display("FAIL load_term_after: data=%0d exp=%0b required data=9 exp=0", data_o, expired_o);
    end
  endtask

  task automatic test_stop();
    load = 1'b1; load_value = 8'd6; count = 1'b0;
    tick();
    load = 1'b0; stop = 1'b1; count = 1'b1;
    tick();
    stop = 1'b0;
    total++;
    if (data_o !== 8'd0 || busy_o !== 1'b0 || expired_o !== 1'b0 || zero_o !== 1'b1) begin
      bad++;
      $display("FAIL stop: data=%0d busy=%0b exp=%0b zero=%0b required data=0 busy=0 exp=0 zero=1",
               data_o, busy_o, expired_o, zero_o);
    end
    $display("stop: data=%0d busy=%0b exp=%0b", data_o, busy_o, expired_o);
    // IDLE ignores count.
    tick();
    total++;
    if (data_o !== 8'd0 || busy_o !== 1'b0 || expired_o !== 1'b0) begin
      bad++;
      $display("FAIL stop_idle: data=%0d busy=%0b exp=%0b required data=0 busy=0 exp=0",
               data_o, busy_o, expired_o);
    end
    count = 1'b0;
  endtask

  task automatic test_load_zero();
    load = 1'b1; load_value = 8'd0; count = 1'b1;
    tick();
    load = 1'b0;
    total++;
    if (data_o !== 8'd0 || zero_o !== 1'b1 || busy_o !== 1'b0 || expired_o !== 1'b0) begin
      bad++;
      $display("FAIL load_zero: data=%0d zero=%0b busy=%0b exp=%0b required data=0 zero=1 busy=0 exp=0",
               data_o, zero_o, busy_o, expired_o);
    end
    $display("load_zero: data=%0d zero=%0b busy=%0b exp=%0b", data_o, zero_o, busy_o, expired_o);
    tick();
    total++;
    if (data_o !== 8'd0 || busy_o !== 1'b0 || expired_o !== 1'b0) begin
      bad++;
      $display("FAIL load_zero_hold: data=%0d busy=%0b exp=%0b required data=0 busy=0 exp=0",
               data_o, busy_o, expired_o);
    end
    count = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; load = 1'b0; load_value = '0; count = 1'b0;
    auto_reload = 1'b0; stop = 1'b0;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_count_toggle();
    test_load_at_terminal();
    test_stop();
    test_load_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_down_counter

// File: doc/down_counter.md
# down_counter

Loadable down-counter/timer, the decrementing counterpart to the free-running up counter in this dataset family. Loads a start value, counts down one step per cycle while `count` is high, flags terminal count with a one-cycle pulse, then stops at zero or auto-reloads. Used as a countdown timer or event budget alongside up-counting blocks.

## Interface
- `WIDTH`, 8, counter and load-value width (≥2)
- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `load`  in  1  synchronous load strobe; highest-priority command
- `load_value`  in  WIDTH  start value, also captured as reload value
- `count`  in  1  decrement enable; sampled only in RUN
- `auto_reload`  in  1  at terminal count: 1 = reload and keep running, 0 = stop in DONE
- `stop`  in  1  synchronous abort to IDLE, clears counter
- `data_o`  out  WIDTH  current count (registered)
- `zero_o`  out  1  `data_o == 0` (combinational from register)
- `expired_o`  out  1  one-cycle pulse, registered, at terminal count
- `busy_o`  out  1  state == RUN

## Operation
- States: IDLE, RUN, DONE.
- Reset (async assert, sync release): state IDLE, `data_o`=0, reload register=0, `expired_o`=0, `busy_o`=0, `zero_o`=1.
- Per-cycle priority: `load` > `stop` > terminal count > decrement > hold.
- `load` (any state): `data_o`←`load_value`, reload reg←`load_value`, `expired_o`←0. Nonzero value → RUN. Zero → IDLE, no pulse.
- `stop` (without `load`): → IDLE, `data_o`←0, no pulse.
- IDLE / DONE: `count` ignored, `data_o` held. No wrap below zero.
- RUN, `count`=0: hold.
- RUN, `count`=1, `data_o`>1: `data_o`←`data_o`−1.
- RUN, `count`=1, `data_o`==1 (terminal):
  - `expired_o`←1 for exactly one cycle.
  - `auto_reload`=1: `data_o`←reload reg, stay RUN.
  - `auto_reload`=0: `data_o`←0, → DONE.
- `expired_o` is 0 in every cycle except the one after a terminal edge.
- Arithmetic is unsigned WIDTH-bit. Decrement never underflows because 1 is the terminal case.

## Timing
- All outputs except `zero_o` are registered. Changes are visible the cycle after the causing input edge.
- Load to first decrement: load at edge N; decrement at edge N+1 if `count`=1.
- Load value V with `count` held high: `expired_o` high after edge N+V, `busy_o` low from then (no reload).
- Auto-reload period with `count` always high: exactly V cycles between `expired_o` pulses.
- `load` on the same edge as terminal count: load wins, no pulse.
- `reset_n` low mid-count: outputs go to reset values immediately, independent of `clock`.

## Structure
- Package `down_counter_pkg`:
  - `state_t` enum {IDLE, RUN, DONE}
  - `DEFAULT_WIDTH`=8
- Single module with no sub-module. One `always_ff` for state, counter, reload reg and `expired_o`. Combinational next-state logic.

## Test plan
- Reset: `reset_n`=0 mid-RUN at `data_o`=5 → immediately `data_o`=0, `zero_o`=1, `busy_o`=0, `expired_o`=0.
- Load 3, `count`=1 continuous, `auto_reload`=0 → `data_o` 3,2,1,0. `expired_o` high only in the cycle `data_o` becomes 0. State DONE; further `count` leaves `data_o`=0.
- Load 4, `auto_reload`=1, `count`=1 for 12 cycles → `data_o` 4,3,2,1,4,3,…. `expired_o` pulses every 4 cycles, `busy_o` stays 1.
- Load 5, toggle `count` 1,0,1,0 → `data_o` decrements only on `count`=1 cycles (5,4,4,3,3).
- `data_o`=1 in RUN, `count`=1 and `load`=9 on the same edge → `data_o`=9, no `expired_o` pulse. Separately, `stop`=1 at `data_o`=6 → IDLE, `data_o`=0, no pulse.
- Load 0 → stays IDLE, `zero_o`=1, `busy_o`=0, no `expired_o`.
